// File: rtl/hdmi_link_pkg.sv
//==============================================================================
// Module  : hdmi_link_pkg
// Brief   : Shared types, SCDC constants and helpers for the HDMI link sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

package hdmi_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_CONFIG    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_BACKOFF   = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6,
        ST_DRAIN     = 3'd7
    } link_state_t;

    localparam logic [6:0] SCDC_DEVICE         = 7'h54;
    localparam logic [7:0] SCDC_SOURCE_VERSION = 8'h02;
    localparam logic [7:0] SCDC_TMDS_CONFIG    = 8'h20;

    // Number of clock cycles in amount/per_second seconds, never below one.
    function automatic int cycles_of(input longint freq, input longint amount,
                                     input longint per_second);
        longint c;
        c = (freq * amount) / per_second;
        return (c < 1) ? 1 : int'(c);
    endfunction

    // {register, data} of SCDC write number idx.
    function automatic logic [15:0] scdc_write(input logic idx, input logic high_ratio);
        return idx ? {SCDC_TMDS_CONFIG, 6'b0, high_ratio, 1'b1}
                   : {SCDC_SOURCE_VERSION, 8'h01};
    endfunction

endpackage

`default_nettype wire

// File: rtl/hdmi_link_sequencer_hpd_debouncer.sv
//==============================================================================
// Module  : hpd_debouncer
// Brief   : Two-flop synchroniser followed by a stability counter on hot-plug.
// Revision: 1.0
//==============================================================================
`default_nettype none

module hpd_debouncer #(
    parameter int CYCLES = 10
) (
    input  logic system_clock,
    input  logic system_reset,
    input  logic hpd_raw,
    output logic hpd_level
);

    localparam int c_count_w = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;
    localparam logic [c_count_w-1:0] c_count_last = c_count_w'(CYCLES - 1);

    logic                 r_meta;
    logic                 r_sync;
    logic                 r_level;
    logic [c_count_w-1:0] r_count;

    // The level flips only after CYCLES consecutive disagreeing samples.
    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_level <= 1'b0;
            r_count <= '0;
        end else begin
            r_meta <= hpd_raw;
            r_sync <= r_meta;
            if (r_sync == r_level) begin
                r_count <= '0;
            end else if (r_count == c_count_last) begin
                r_level <= r_sync;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign hpd_level = r_level;

endmodule

`default_nettype wire

// File: rtl/hdmi_link_sequencer.sv
//==============================================================================
// Module  : hdmi_link_sequencer
// Brief   : Hot-plug debounce, SCDC configuration over I2C and TMDS enable.
// Revision: 1.0
//==============================================================================
`default_nettype none

module hdmi_link_sequencer
    import hdmi_link_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 200_000_000,
    parameter int DEBOUNCE_US     = 10_000,
    parameter int SETTLE_MS       = 100,
    parameter int RETRY_MS        = 50,
    parameter int MAX_RETRIES     = 3,
    parameter int SCRAMBLE        = 1,
    parameter int HIGH_TMDS_RATIO = 1
) (
    input  logic       system_clock,
    input  logic       system_reset,
    input  logic       hpd,
    output logic       i2c_req_valid,
    input  logic       i2c_req_ready,
    output logic [6:0] i2c_req_device,
    output logic [7:0] i2c_req_register,
    output logic [7:0] i2c_req_data,
    input  logic       i2c_done,
    input  logic       i2c_nack,
    output logic       tx_enable,
    output logic       scrambler_enable,
    output logic       run,
    output logic       link_error
);

    localparam int c_debounce_cycles =
        cycles_of(longint'(CLOCK_FREQUENCY), longint'(DEBOUNCE_US), 64'd1_000_000);
    localparam int c_settle_cycles =
        cycles_of(longint'(CLOCK_FREQUENCY), longint'(SETTLE_MS), 64'd1_000);
    localparam int c_retry_cycles =
        cycles_of(longint'(CLOCK_FREQUENCY), longint'(RETRY_MS), 64'd1_000);
    localparam int c_timer_max =
        (c_settle_cycles > c_retry_cycles) ? c_settle_cycles : c_retry_cycles;
    localparam int c_timer_w = (c_timer_max > 1) ? $clog2(c_timer_max) : 1;
    localparam logic [c_timer_w-1:0] c_settle_load = c_timer_w'(c_settle_cycles - 1);
    localparam logic [c_timer_w-1:0] c_retry_load  = c_timer_w'(c_retry_cycles - 1);
    localparam int c_retry_w = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [c_retry_w-1:0] c_retry_last = c_retry_w'(MAX_RETRIES - 1);
    localparam logic [15:0] c_write0 = scdc_write(1'b0, HIGH_TMDS_RATIO != 0);
    localparam logic [15:0] c_write1 = scdc_write(1'b1, HIGH_TMDS_RATIO != 0);

    logic                 w_hpd_db;
    logic                 w_drop;
    logic                 w_in_flight;
    link_state_t          r_state;
    logic [c_timer_w-1:0] r_timer;
    logic [c_retry_w-1:0] r_retries;
    logic                 r_index;

    hpd_debouncer #(
        .CYCLES (c_debounce_cycles)
    ) u_hpd_debouncer (
        .system_clock (system_clock),
        .system_reset (system_reset),
        .hpd_raw      (hpd),
        .hpd_level    (w_hpd_db)
    );

    assign i2c_req_device = SCDC_DEVICE;

    // A write the master has taken (or is taking this edge) must be drained before IDLE.
    assign w_drop      = !w_hpd_db && (r_state != ST_IDLE) && (r_state != ST_DRAIN);
    assign w_in_flight = ((r_state == ST_WAIT_DONE) && !i2c_done) ||
                         ((r_state == ST_CONFIG) && i2c_req_valid && i2c_req_ready);

    always_ff @(posedge system_clock or posedge system_reset) begin
        if (system_reset) begin
            r_state          <= ST_IDLE;
            r_timer          <= '0;
            r_retries        <= '0;
            r_index          <= 1'b0;
            i2c_req_valid    <= 1'b0;
            i2c_req_register <= 8'h00;
            i2c_req_data     <= 8'h00;
            tx_enable        <= 1'b0;
            scrambler_enable <= 1'b0;
            run              <= 1'b0;
            link_error       <= 1'b0;
        end else if (w_drop) begin
            r_state          <= w_in_flight ? ST_DRAIN : ST_IDLE;
            r_retries        <= '0;
            r_index          <= 1'b0;
            i2c_req_valid    <= 1'b0;
            tx_enable        <= 1'b0;
            scrambler_enable <= 1'b0;
            run              <= 1'b0;
            link_error       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hpd_db) begin
                        r_state   <= ST_SETTLE;
                        r_timer   <= c_settle_load;
                        r_retries <= '0;
                        r_index   <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else if (SCRAMBLE != 0) begin
                        r_state                         <= ST_CONFIG;
                        i2c_req_valid                   <= 1'b1;
                        {i2c_req_register, i2c_req_data} <= c_write0;
                    end else begin
                        r_state   <= ST_RUN;
                        tx_enable <= 1'b1;
                        run       <= 1'b1;
                    end
                end
                ST_CONFIG: begin
                    if (i2c_req_valid && i2c_req_ready) begin
                        r_state       <= ST_WAIT_DONE;
                        i2c_req_valid <= 1'b0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i2c_done && !i2c_nack) begin
                        r_retries <= '0;
                        if (r_index) begin
                            r_state          <= ST_RUN;
                            tx_enable        <= 1'b1;
                            scrambler_enable <= (SCRAMBLE != 0);
                            run              <= 1'b1;
                        end else begin
                            r_state                         <= ST_CONFIG;
                            r_index                         <= 1'b1;
                            i2c_req_valid                   <= 1'b1;
                            {i2c_req_register, i2c_req_data} <= c_write1;
                        end
                    end else if (i2c_done) begin
                        r_retries <= r_retries + 1'b1;
                        if (r_retries == c_retry_last) begin
                            r_state    <= ST_FAULT;
                            link_error <= 1'b1;
                        end else begin
                            r_state <= ST_BACKOFF;
                            r_timer <= c_retry_load;
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 1'b1;
                    end else begin
                        r_state       <= ST_CONFIG;
                        i2c_req_valid <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (i2c_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= r_state;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_link_sequencer.sv
//==============================================================================
// Module  : tb_hdmi_link_sequencer
// Brief   : Randomised I2C responder and write-sequence model for the link sequencer.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_hdmi_link_sequencer;

    localparam int DEB    = 10;
    localparam int SETTLE = 1000;
    localparam int RETRY  = 1000;
    localparam int MAXR   = 3;
    localparam logic [15:0] W0 = 16'h0201;
    localparam logic [15:0] W1 = 16'h2003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a, hpd_a, ready_a, done_a, nack_a;
    logic       valid_a, tx_a, scr_a, run_a, err_a;
    logic [6:0] dev_a;
    logic [7:0] reg_a, data_a;
    logic       rst_b, hpd_b, ready_b, done_b, nack_b;
    logic       valid_b, tx_b, scr_b, run_b, err_b;
    logic [6:0] dev_b;
    logic [7:0] reg_b, data_b;

    hdmi_link_sequencer #(
        .CLOCK_FREQUENCY(1_000_000), .DEBOUNCE_US(DEB), .SETTLE_MS(1), .RETRY_MS(1),
        .MAX_RETRIES(MAXR), .SCRAMBLE(1), .HIGH_TMDS_RATIO(1)
    ) dut_a (
        .system_clock(clk), .system_reset(rst_a), .hpd(hpd_a),
        .i2c_req_valid(valid_a), .i2c_req_ready(ready_a), .i2c_req_device(dev_a),
        .i2c_req_register(reg_a), .i2c_req_data(data_a), .i2c_done(done_a),
        .i2c_nack(nack_a), .tx_enable(tx_a), .scrambler_enable(scr_a), .run(run_a),
        .link_error(err_a)
    );

    hdmi_link_sequencer #(
        .CLOCK_FREQUENCY(1_000_000), .DEBOUNCE_US(DEB), .SETTLE_MS(1), .RETRY_MS(1),
        .MAX_RETRIES(MAXR), .SCRAMBLE(0), .HIGH_TMDS_RATIO(1)
    ) dut_b (
        .system_clock(clk), .system_reset(rst_b), .hpd(hpd_b),
        .i2c_req_valid(valid_b), .i2c_req_ready(ready_b), .i2c_req_device(dev_b),
        .i2c_req_register(reg_b), .i2c_req_data(data_b), .i2c_done(done_b),
        .i2c_nack(nack_b), .tx_enable(tx_b), .scrambler_enable(scr_b), .run(run_b),
        .link_error(err_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] log_q[$];
    int          acc_cyc_q[$];
    bit          plan_q[$];
    logic [15:0] exp_q[$];
    bit          exp_fault;
    bit          hold20 = 1'b0;
    bit          ready_rand = 1'b0;
    bit          tx_ever = 1'b0;
    int          last_done_cyc = 0;

    // I2C master stand-in: accepts, answers after a short delay using the NACK plan.
    initial begin
        bit          pending;
        bit          nk;
        bit          pv;
        int          delay;
        logic [7:0]  pend_reg;
        logic [15:0] prev;
        logic [15:0] cur;
        pending = 0; nk = 0; pv = 0; delay = 0; pend_reg = 8'h00; prev = '0;
        ready_a = 1'b0; done_a = 1'b0; nack_a = 1'b0;
        forever begin
            @(negedge clk);
            done_a = 1'b0;
            nack_a = 1'b0;
            if (rst_a) begin
                pending = 0;
                pv      = 0;
                ready_a = 1'b0;
            end else begin
                cur = {reg_a, data_a};
                if (pv && valid_a) check_eq("req_stable", 32'(cur), 32'(prev));
                pv   = valid_a;
                prev = cur;
                if (tx_a) tx_ever = 1'b1;
                if (pending) begin
                    ready_a = 1'b0;
                    if (!(hold20 && pend_reg == 8'h20)) begin
                        if (delay == 0) begin
                            done_a        = 1'b1;
                            nack_a        = nk;
                            pending       = 0;
                            last_done_cyc = cyc;
                        end else begin
                            delay--;
                        end
                    end
                end else begin
                    ready_a = ready_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                    if (valid_a && ready_a) begin
                        log_q.push_back(cur);
                        acc_cyc_q.push_back(cyc);
                        check_eq("device", 32'(dev_a), 32'h54);
                        pending  = 1;
                        delay    = ready_rand ? int'($urandom_range(0, 3)) : 0;
                        nk       = (plan_q.size() > 0) ? plan_q.pop_front() : 1'b0;
                        pend_reg = reg_a;
                    end
                end
            end
        end
    end

    // Expected write sequence and outcome, straight from the retry rules.
    task automatic build_expect();
        int p;
        int nacks;
        int idx;
        bit b;
        p = 0; nacks = 0; idx = 0;
        exp_q.delete();
        exp_fault = 1'b0;
        while (idx < 2) begin
            exp_q.push_back((idx == 0) ? W0 : W1);
            b = (p < plan_q.size()) ? plan_q[p] : 1'b0;
            p++;
            if (b) begin
                nacks++;
                if (nacks == MAXR) begin
                    exp_fault = 1'b1;
                    break;
                end
            end else begin
                idx++;
                nacks = 0;
            end
        end
    endtask

    task automatic set_plan(input logic [7:0] bits, input int n);
        plan_q.delete();
        for (int i = 0; i < n; i++) plan_q.push_back(bits[i]);
    endtask

    task automatic start_link(input bit rnd);
        rst_a = 1'b1;
        hpd_a = 1'b0;
        hold20 = 1'b0;
        ready_rand = rnd;
        log_q.delete();
        acc_cyc_q.delete();
        tx_ever = 1'b0;
        build_expect();
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(valid_a), 0);
        check_eq("rst_run", 32'({tx_a, scr_a, run_a, err_a}), 0);
        rst_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic finish_link(input string tag);
        int  seen;
        bit  hit;
        seen = 0;
        hit  = 0;
        for (int i = 0; i < 15000; i++) begin
            @(negedge clk);
            if (run_a || err_a) begin
                hit  = 1;
                seen = cyc;
                break;
            end
        end
        if (!hit) check_eq({tag, "_timeout"}, 0, 1);
        check_eq({tag, "_done_to_outcome"}, 32'(seen - last_done_cyc), 1);
        repeat (5) @(negedge clk);
        check_eq({tag, "_txn_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check_eq($sformatf("%s_txn%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
        check_eq({tag, "_run"}, 32'({run_a, tx_a, scr_a}), exp_fault ? 0 : 32'h7);
        check_eq({tag, "_link_error"}, 32'(err_a), 32'(exp_fault));
        check_eq({tag, "_valid_idle"}, 32'(valid_a), 0);
    endtask

    initial begin
        int n;
        int gap;
        bit hit;
        int reqs;
        rst_a = 1'b1; hpd_a = 1'b0;
        rst_b = 1'b1; hpd_b = 1'b0; ready_b = 1'b1; done_b = 1'b0; nack_b = 1'b0;

        // All writes acknowledged; measure hot-plug to first request latency.
        set_plan(8'h00, 0);
        start_link(1'b0);
        hpd_a = 1'b1;
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            n++;
            #1;
            if (valid_a) break;
        end
        check_eq("first_req_latency_ok",
                 32'((n >= 2 + DEB + SETTLE - 1) && (n <= 2 + DEB + SETTLE + 3)), 1);
        finish_link("ack");

        // Short hot-plug glitch must not start anything.
        set_plan(8'h00, 0);
        start_link(1'b0);
        hpd_a = 1'b1;
        repeat ($urandom_range(3, DEB - 2)) @(negedge clk);
        hpd_a = 1'b0;
        repeat (SETTLE + 100) @(negedge clk);
        check_eq("glitch_reqs", 32'(log_q.size()), 0);
        check_eq("glitch_outputs", 32'({valid_a, tx_a, scr_a, run_a, err_a}), 0);
        check_eq("glitch_tx_ever", 32'(tx_ever), 0);

        // Second write NACKed twice, then acknowledged.
        set_plan(8'b0000_0110, 4);
        start_link(1'b0);
        hpd_a = 1'b1;
        finish_link("retry");
        if (acc_cyc_q.size() >= 3) begin
            gap = acc_cyc_q[2] - acc_cyc_q[1];
            check_eq("backoff_gap_ok", 32'((gap >= RETRY + 1) && (gap <= RETRY + 4)), 1);
        end else begin
            check_eq("backoff_accepts", 32'(acc_cyc_q.size()), 3);
        end

        // First write NACKed until the retry limit; hot-plug drop clears the error.
        set_plan(8'b0000_0111, 3);
        start_link(1'b0);
        hpd_a = 1'b1;
        finish_link("fault");
        hpd_a = 1'b0;
        repeat (DEB + 8) @(negedge clk);
        check_eq("fault_cleared", 32'({err_a, run_a, tx_a}), 0);

        // Random NACK patterns with a ready/done timing jitter.
        for (int it = 0; it < 6; it++) begin
            plan_q.delete();
            for (int k = 0; k < 9; k++) plan_q.push_back($urandom_range(0, 2) == 0);
            start_link(1'b1);
            hpd_a = 1'b1;
            finish_link($sformatf("rnd%0d", it));
        end

        // Unplug after the TMDS_Config write is accepted but before it completes.
        set_plan(8'h00, 0);
        start_link(1'b0);
        hold20 = 1'b1;
        hpd_a = 1'b1;
        hit = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (log_q.size() == 2) begin
                hit = 1;
                break;
            end
        end
        check_eq("drain_reached_w1", 32'(hit), 1);
        repeat (3) @(negedge clk);
        hpd_a = 1'b0;
        repeat (DEB + 6) @(negedge clk);
        check_eq("drain_outputs", 32'({valid_a, tx_a, scr_a, run_a, err_a}), 0);
        hold20 = 1'b0;
        repeat (SETTLE + 200) @(negedge clk);
        check_eq("drain_reqs", 32'(log_q.size()), 2);
        check_eq("drain_tx_ever", 32'(tx_ever), 0);
        check_eq("drain_run", 32'(run_a), 0);

        // Scrambling disabled: straight to RUN, then asynchronous reset.
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        hpd_b = 1'b1;
        reqs = 0;
        hit  = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (valid_b) reqs++;
            if (run_b) begin
                hit = 1;
                break;
            end
        end
        check_eq("noscr_reached_run", 32'(hit), 1);
        check_eq("noscr_outputs", 32'({run_b, tx_b, scr_b, err_b}), 32'hC);
        check_eq("noscr_reqs", 32'(reqs), 0);
        @(negedge clk);
        #2 rst_b = 1'b1;
        #1;
        check_eq("async_reset", 32'({valid_b, run_b, tx_b, scr_b, err_b}), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
